ps_reg_node: RTL and testbench
==============================

PS_REG_NODE -- requirements
Module: ps_reg_node

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register and data-bus width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, word-address width; register count 2^ADDR_WIDTH.
REQ-003 SHALL have parameter ID_VALUE, default 32'h4D55_444B, constant returned by register 0.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  PS request valid.
REQ-007 SHALL have port req_ready  output  1  PS request accepted when req_valid and req_ready are both high.
REQ-008 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_WIDTH  register word address.
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port req_wstrb  input  DATA_WIDTH/8  per-byte write enable.
REQ-012 SHALL have port rsp_valid  output  1  response valid.
REQ-013 SHALL have port rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-014 SHALL have port rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
REQ-015 SHALL have port rsp_err  output  1  1 = write to read-only register.
REQ-016 SHALL have port rsp_write  output  1  echoes req_write of the originating request.

Function
REQ-017 SHALL implement this register map: addr 0 ID (read-only, ID_VALUE); addr 1 CTRL (RW; bit0 = counter enable; bit1 = counter clear, write-1, self-clearing, reads 0); addr 2 COUNT (read-only); addr 3 and up SCRATCH (RW).
REQ-018 SHALL produce exactly one response per accepted request, in acceptance order.
REQ-019 SHALL commit an accepted write at the acceptance edge, updating only the bytes whose req_wstrb bit is 1.
REQ-020 SHALL treat req_wstrb = 0 on a RW register as a successful no-op (rsp_err = 0).
REQ-021 SHALL leave state unchanged on a write to addr 0 or addr 2, and SHALL return rsp_err = 1 for it.
REQ-022 SHALL capture read data at the acceptance edge, so a read accepted the cycle after a write to the same address returns the new value.
REQ-023 SHALL register responses in a 2-entry FIFO, so a response is visible on rsp_valid the cycle after acceptance (latency 1).
REQ-024 SHALL drive req_ready = !rst && (FIFO occupancy < 2), with no combinational path from rsp_ready.
REQ-025 SHALL, on a simultaneous push and pop, leave occupancy unchanged and keep order intact.
REQ-026 SHALL hold rsp_valid, rsp_rdata, rsp_err and rsp_write stable while rsp_valid = 1 and rsp_ready = 0.
REQ-027 SHALL increment COUNT by 1 per cycle while CTRL[0] = 1, wrapping from 2^DATA_WIDTH-1 to 0.
REQ-028 SHALL load COUNT with 0 on the edge that accepts a CTRL write with bit1 = 1, overriding any increment that cycle; increments resume the next cycle if bit0 = 1.
REQ-029 SHALL return, for a COUNT read, the COUNT value present before the acceptance edge.

Reset
REQ-030 SHALL, while rst = 1 at a clock edge, clear CTRL, COUNT and all SCRATCH registers to 0 and empty the FIFO.
REQ-031 SHALL hold rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, rsp_write = 0 and req_ready = 0 while rst = 1.
REQ-032 SHALL discard any in-flight responses on reset asserted mid-operation, and SHALL assert req_ready = 1 on the first cycle after rst falls.

Verification
REQ-033 SHALL pass: read addr 0 after reset -> one cycle later rsp_valid = 1, rsp_rdata = 32'h4D55_444B, rsp_err = 0.
REQ-034 SHALL pass: write addr 5 = 32'hAABBCCDD with wstrb 4'b0101, then read addr 5 back-to-back -> rsp_rdata = 32'h00BB00DD; write response has rsp_write = 1, rsp_err = 0.
REQ-035 SHALL pass: write addr 2 = 32'h1234 -> rsp_err = 1; a subsequent read of addr 2 returns a value unchanged by the write.
REQ-036 SHALL pass: write CTRL = 1, wait 10 cycles, read COUNT -> value matches cycle count; then write CTRL = 3 -> COUNT = 0 after that edge and counts from 1 on the following cycle.
REQ-037 SHALL pass: rsp_ready = 0 with 3 consecutive reads issued -> req_ready drops after 2 acceptances; on raising rsp_ready, responses drain in order and req_ready returns to 1.
REQ-038 SHALL pass: rst pulsed while 2 responses are queued -> rsp_valid = 0 the next cycle, SCRATCH reads back 0, and no stale response appears.

Source files
------------

// File: rtl/ps_reg_node.sv
// ps_reg_node
// -----------------------------------------------------------------------------
// Small register node on a valid/ready request/response bus. Requests are
// accepted one per cycle; each accepted request produces exactly one response,
// queued in a 2-entry FIFO and presented in acceptance order one cycle later.
//
// Register map (word addresses):
//   0      ID       read-only, returns ID_VALUE
//   1      CTRL     bit0 = counter enable (RW)
//                   bit1 = counter clear (write-1, self-clearing, reads 0)
//                   all other bits read 0
//   2      COUNT    read-only free-running counter, enabled by CTRL[0]
//   3..N-1 SCRATCH  read/write, byte-strobed
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  request valid
//   req_ready  request accepted when req_valid && req_ready
//   req_write  1 = write, 0 = read
//   req_addr   register word address
//   req_wdata  write data
//   req_wstrb  per-byte write enable
//   rsp_valid  response valid
//   rsp_ready  response consumed when rsp_valid && rsp_ready
//   rsp_rdata  read data (0 for writes)
//   rsp_err    1 = write to a read-only register
//   rsp_write  echoes req_write of the originating request
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. A source holding valid high keeps its payload stable until the beat
// transfers. Here rsp_valid/rsp_* come straight from FIFO registers, so they
// are stable while rsp_ready is low, and req_ready depends only on rst and the
// registered FIFO occupancy (no path from rsp_ready or req_valid).
// -----------------------------------------------------------------------------
module ps_reg_node #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'h4D55_444B
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_write
);

    localparam int NUM_REGS  = 1 << ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ID    = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_COUNT = ADDR_WIDTH'(2);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        logic                  write;
    } rsp_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic                  ctrl_en;
    logic [DATA_WIDTH-1:0] count;
    // Only addresses 3 and up have backing storage.
    logic [DATA_WIDTH-1:0] scratch [3:NUM_REGS-1];

    logic [1:0]            fifo_cnt;
    rsp_t                  ent0;     // head of the response FIFO
    rsp_t                  ent1;     // second entry, valid when fifo_cnt == 2

    // -------------------------------------------------------------------------
    // Handshake qualifiers
    // -------------------------------------------------------------------------
    logic push;
    logic pop;

    assign req_ready = !rst && (fifo_cnt < 2'd2);
    assign rsp_valid = !rst && (fifo_cnt != 2'd0);

    assign push = req_valid && req_ready;
    assign pop  = rsp_valid && rsp_ready;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic addr_ro;
    logic wr_accept;
    logic ctrl_wr;
    logic count_clear;

    assign addr_ro     = (req_addr == ADDR_ID) || (req_addr == ADDR_COUNT);
    assign wr_accept   = push && req_write;
    // Both CTRL bits live in byte 0, so only that strobe matters.
    assign ctrl_wr     = wr_accept && (req_addr == ADDR_CTRL) && req_wstrb[0];
    assign count_clear = ctrl_wr && req_wdata[1];

    // Read mux: sampled from register state before the acceptance edge, so a
    // COUNT read returns the pre-edge value and a read right after a write
    // sees the already-committed data.
    logic [DATA_WIDTH-1:0] rd_value;

    always_comb begin
        rd_value = '0;
        if (req_addr == ADDR_ID) begin
            rd_value = ID_VALUE;
        end else if (req_addr == ADDR_CTRL) begin
            rd_value = {{(DATA_WIDTH-1){1'b0}}, ctrl_en};
        end else if (req_addr == ADDR_COUNT) begin
            rd_value = count;
        end else begin
            for (int i = 3; i < NUM_REGS; i++) begin
                if (req_addr == ADDR_WIDTH'(i)) begin
                    rd_value = scratch[i];
                end
            end
        end
    end

    rsp_t new_rsp;

    always_comb begin
        new_rsp       = '0;
        new_rsp.rdata = req_write ? '0 : rd_value;
        new_rsp.err   = req_write && addr_ro;
        new_rsp.write = req_write;
    end

    // -------------------------------------------------------------------------
    // CTRL register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl_en <= req_wdata[0];
        end
    end

    // -------------------------------------------------------------------------
    // COUNT: clear wins over increment on the accepting edge; the enable used
    // here is the value before that edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count_clear) begin
            count <= '0;
        end else if (ctrl_en) begin
            count <= count + DATA_WIDTH'(1);
        end
    end

    // -------------------------------------------------------------------------
    // SCRATCH registers, byte-strobed. A zero strobe is a harmless no-op.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 3; i < NUM_REGS; i++) begin
                scratch[i] <= '0;
            end
        end else if (wr_accept) begin
            for (int i = 3; i < NUM_REGS; i++) begin
                if (req_addr == ADDR_WIDTH'(i)) begin
                    for (int b = 0; b < NUM_BYTES; b++) begin
                        if (req_wstrb[b]) begin
                            scratch[i][b*8 +: 8] <= req_wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response FIFO (2 entries, shift-style: ent0 is always the head).
    // Push+pop together can only happen with one entry held, because a full
    // FIFO drops req_ready; the new response then replaces the departing head.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_cnt <= 2'd0;
            ent0     <= '0;
            ent1     <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        ent0 <= new_rsp;
                    end else begin
                        ent1 <= new_rsp;
                    end
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    ent0     <= ent1;
                    fifo_cnt <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    ent0 <= new_rsp;
                end
                default: begin
                end
            endcase
        end
    end

    // Payload reads as zero whenever no response is presented (including
    // during reset).
    assign rsp_rdata = rsp_valid ? ent0.rdata : '0;
    assign rsp_err   = rsp_valid ? ent0.err   : 1'b0;
    assign rsp_write = rsp_valid ? ent0.write : 1'b0;

endmodule

// File: tb/tb_ps_reg_node.sv
// tb_ps_reg_node
// -----------------------------------------------------------------------------
// Directed bench for ps_reg_node (default parameters). Inputs change 1 time
// unit after a rising edge; outputs are sampled at that same point, i.e. after
// the registers have settled.
// -----------------------------------------------------------------------------
module tb_ps_reg_node;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_write;

    int checks = 0;
    int errors = 0;

    ps_reg_node dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_write (rsp_write)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and return 1 unit after the edge that accepts it.
    // With rsp_ready high and an empty FIFO, that response is now presented.
    task automatic issue(input logic w, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        int waited;
        waited    = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        while (!req_ready && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL issue_timeout: req_ready stayed %b, expected 1 within 20 cycles", req_ready);
        end else begin
            step();
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
        checks++;
        if ({rsp_rdata, rsp_err, rsp_write} !== 34'd0) begin
            errors++; $display("FAIL rst_payload: got %h/%b/%b expected 0/0/0", rsp_rdata, rsp_err, rsp_write);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", req_ready); end
        step();
    endtask

    task automatic test_id_read();
        issue(1'b0, 4'd0, 32'h0, 4'h0);
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL id_valid: got %b expected 1", rsp_valid); end
        checks++;
        if (rsp_rdata !== 32'h4D55_444B) begin errors++; $display("FAIL id_rdata: got %h expected 4d55444b", rsp_rdata); end
        checks++;
        if (rsp_err !== 1'b0 || rsp_write !== 1'b0) begin
            errors++; $display("FAIL id_flags: got err=%b write=%b expected 0/0", rsp_err, rsp_write);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL id_drained: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_strobe();
        issue(1'b1, 4'd5, 32'hAABB_CCDD, 4'b0101);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL strb_wr_rsp: got v=%b w=%b e=%b d=%h expected 1/1/0/0", rsp_valid, rsp_write, rsp_err, rsp_rdata);
        end
        issue(1'b0, 4'd5, 32'h0, 4'h0);
        checks++;
        if (rsp_rdata !== 32'h00BB_00DD || rsp_write !== 1'b0) begin
            errors++; $display("FAIL strb_rd: got %h w=%b expected 00bb00dd w=0", rsp_rdata, rsp_write);
        end
        issue(1'b1, 4'd5, 32'hFFFF_FFFF, 4'b0000);
        checks++;
        if (rsp_err !== 1'b0 || rsp_write !== 1'b1) begin
            errors++; $display("FAIL strb_zero_rsp: got err=%b write=%b expected 0/1", rsp_err, rsp_write);
        end
        issue(1'b0, 4'd5, 32'h0, 4'h0);
        checks++;
        if (rsp_rdata !== 32'h00BB_00DD) begin errors++; $display("FAIL strb_zero_rd: got %h expected 00bb00dd", rsp_rdata); end
        issue(1'b1, 4'd5, 32'h1122_3344, 4'b1010);
        issue(1'b0, 4'd5, 32'h0, 4'h0);
        checks++;
        if (rsp_rdata !== 32'h11BB_33DD) begin errors++; $display("FAIL strb_upper_rd: got %h expected 11bb33dd", rsp_rdata); end
        step();
    endtask

    task automatic test_read_only();
        issue(1'b1, 4'd2, 32'h0000_1234, 4'hF);
        checks++;
        if (rsp_err !== 1'b1 || rsp_write !== 1'b1) begin
            errors++; $display("FAIL ro_count_err: got err=%b write=%b expected 1/1", rsp_err, rsp_write);
        end
        issue(1'b0, 4'd2, 32'h0, 4'h0);
        checks++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL ro_count_rd: got %h err=%b expected 0 err=0", rsp_rdata, rsp_err);
        end
        issue(1'b1, 4'd0, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if (rsp_err !== 1'b1) begin errors++; $display("FAIL ro_id_err: got %b expected 1", rsp_err); end
        issue(1'b0, 4'd0, 32'h0, 4'h0);
        checks++;
        if (rsp_rdata !== 32'h4D55_444B) begin errors++; $display("FAIL ro_id_rd: got %h expected 4d55444b", rsp_rdata); end
        step();
    endtask

    task automatic test_counter();
        // Enable accepted at edge E0; counting starts at E1.
        issue(1'b1, 4'd1, 32'h1, 4'h1);
        repeat (10) step();
        // Read accepted at E11 sees the 10 increments from E1..E10.
        issue(1'b0, 4'd2, 32'h0, 4'h0);
        checks++;
        if (rsp_rdata !== 32'd10) begin errors++; $display("FAIL cnt_after_10: got %0d expected 10", rsp_rdata); end
        // Clear+enable at E12, then reads at E13 and E14.
        issue(1'b1, 4'd1, 32'h3, 4'h1);
        issue(1'b0, 4'd2, 32'h0, 4'h0);
        checks++;
        if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL cnt_cleared: got %0d expected 0", rsp_rdata); end
        issue(1'b0, 4'd2, 32'h0, 4'h0);
        checks++;
        if (rsp_rdata !== 32'd1) begin errors++; $display("FAIL cnt_resume: got %0d expected 1", rsp_rdata); end
        issue(1'b0, 4'd1, 32'h0, 4'h0);
        checks++;
        if (rsp_rdata !== 32'd1) begin errors++; $display("FAIL ctrl_readback: got %h expected 1", rsp_rdata); end
        // Disable at E16: the increment on that edge still happens (4).
        issue(1'b1, 4'd1, 32'h0, 4'h1);
        issue(1'b0, 4'd2, 32'h0, 4'h0);
        checks++;
        if (rsp_rdata !== 32'd4) begin errors++; $display("FAIL cnt_stopped: got %0d expected 4", rsp_rdata); end
        repeat (5) step();
        issue(1'b0, 4'd2, 32'h0, 4'h0);
        checks++;
        if (rsp_rdata !== 32'd4) begin errors++; $display("FAIL cnt_held: got %0d expected 4", rsp_rdata); end
        step();
    endtask

    task automatic test_backpressure();
        issue(1'b1, 4'd3, 32'h1111_1111, 4'hF);
        issue(1'b1, 4'd4, 32'h2222_2222, 4'hF);
        step();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd3;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b expected 1", req_ready); end
        step();
        req_addr = 4'd4;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b expected 1", req_ready); end
        step();
        req_addr = 4'd5;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", req_ready); end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1111_1111) begin
            errors++; $display("FAIL bp_head: got v=%b %h expected 1 11111111", rsp_valid, rsp_rdata);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1111_1111 || req_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold: got v=%b %h rdy=%b expected 1 11111111 0", rsp_valid, rsp_rdata, req_ready);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_no_comb: got %b expected 0", req_ready); end
        step();
        checks++;
        if (rsp_rdata !== 32'h2222_2222 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_drain1: got %h rdy=%b expected 22222222 1", rsp_rdata, req_ready);
        end
        step();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11BB_33DD) begin
            errors++; $display("FAIL bp_drain2: got v=%b %h expected 1 11bb33dd", rsp_valid, rsp_rdata);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_empty: got v=%b rdy=%b expected 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 4'd6, 32'hCAFE_F00D, 4'hF);
        step();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd6;
        step();
        req_addr = 4'd3;
        step();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL mid_queued: got v=%b rdy=%b expected 1 0", rsp_valid, req_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL mid_in_rst: got v=%b rdy=%b expected 0 0", rsp_valid, req_ready);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL mid_after_rst: got v=%b rdy=%b expected 0 1", rsp_valid, req_ready);
        end
        rsp_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %b expected 0", rsp_valid); end
        issue(1'b0, 4'd6, 32'h0, 4'h0);
        checks++;
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL mid_scratch6: got %h expected 0", rsp_rdata); end
        issue(1'b0, 4'd3, 32'h0, 4'h0);
        checks++;
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL mid_scratch3: got %h expected 0", rsp_rdata); end
        issue(1'b0, 4'd1, 32'h0, 4'h0);
        checks++;
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL mid_ctrl: got %h expected 0", rsp_rdata); end
        issue(1'b0, 4'd2, 32'h0, 4'h0);
        checks++;
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL mid_count: got %h expected 0", rsp_rdata); end
        step();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 4'd0;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
        rsp_ready = 1'b1;

        test_reset();
        test_id_read();
        test_strobe();
        test_read_only();
        test_counter();
        test_backpressure();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
